lsu_mem_stage: RTL and testbench

- Load/store unit for the MEM stage of the RV32I datapath.
- Consumes the decoded load/store operation from EX/MEM: opcode class, funct3 (load_funct3_t / store_funct3_t), effective address and rs2 data.
- Drives the word-addressed data-memory port with byte enables (rv32i_mem_wmask) and waits for the memory response.
- Returns the aligned, sign/zero-extended load word for writeback and stalls the pipeline while an access is outstanding.

---
 rtl/lsu_mem_stage.sv | 129 ++++++++++++
 tb/tb_lsu_mem_stage.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: RV32I MEM-stage load/store unit with byte enables, load extension and response watchdog.
// Define LSU_MISALIGN_TRAP_EN to complete misaligned accesses immediately with misalign_err instead of issuing them.
module lsu_mem_stage #(
  parameter int RESP_TIMEOUT = 0,
  parameter int TO_CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        stall,
  output logic        done_valid,
  output logic [31:0] load_data,
  output logic        misalign_err,
  output logic        timeout_err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic op_load;
  logic [2:0] f3;
  logic [1:0] lo;
  logic [TO_CNT_W-1:0] cnt;
  logic accept, trap, to_hit;
  logic [3:0] mbe_n;
  logic [31:0] wdata_n, ext;
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    accept = state == IDLE && req_valid && (is_load || is_store);
    stall = accept || state == BUSY;
    mbe_n = is_load ? 4'b1111 :
            funct3 == 3'b000 ? 4'b0001 << addr[1:0] :
            funct3 == 3'b001 ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
    wdata_n = is_load ? 32'h0 :
              funct3 == 3'b000 ? {4{store_data[7:0]}} :
              funct3 == 3'b001 ? {2{store_data[15:0]}} : store_data;
    b = dmem_rdata[{lo, 3'b000} +: 8];
    h = lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ext = f3 == 3'b000 ? {{24{b[7]}}, b} :
          f3 == 3'b100 ? {24'h0, b} :
          f3 == 3'b001 ? {{16{h[15]}}, h} :
          f3 == 3'b101 ? {16'h0, h} : dmem_rdata;
    // Response on the final watchdog cycle still counts as a normal completion
    to_hit = RESP_TIMEOUT != 0 && cnt == TO_CNT_W'(RESP_TIMEOUT - 1);
`ifdef LSU_MISALIGN_TRAP_EN
    // Loads decode size from funct3[1:0] alone; stores with funct3[2] set fall back to word
    trap = accept && (
      (funct3[1:0] == 2'b01 && (is_load || !funct3[2]) && addr[0]) ||
      (!(funct3[1] == 1'b0 && (is_load || !funct3[2])) && addr[1:0] != 2'b00));
`else
    trap = 1'b0;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_load <= 1'b0;
      f3 <= 3'b000;
      lo <= 2'b00;
      cnt <= '0;
      dmem_read <= 1'b0;
      dmem_write <= 1'b0;
      dmem_address <= 32'h0;
      dmem_wdata <= 32'h0;
      dmem_mbe <= 4'b0000;
      done_valid <= 1'b0;
      load_data <= 32'h0;
      misalign_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_valid <= 1'b0;
          misalign_err <= 1'b0;
          timeout_err <= 1'b0;
          if (accept) begin
            op_load <= is_load;
            f3 <= funct3;
            lo <= addr[1:0];
            cnt <= '0;
            dmem_address <= {addr[31:2], 2'b00};
            dmem_mbe <= mbe_n;
            dmem_wdata <= wdata_n;
            if (trap) begin
              state <= DONE;
              done_valid <= 1'b1;
              misalign_err <= 1'b1;
              load_data <= 32'h0;
            end else begin
              state <= BUSY;
              dmem_read <= is_load;
              dmem_write <= !is_load;
            end
          end
        end
        BUSY: begin
          if (dmem_resp || to_hit) begin
            state <= DONE;
            dmem_read <= 1'b0;
            dmem_write <= 1'b0;
            done_valid <= 1'b1;
            timeout_err <= !dmem_resp;
            load_data <= dmem_resp && op_load ? ext : 32'h0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done_valid <= 1'b0;
          misalign_err <= 1'b0;
          timeout_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed-vector bench for lsu_mem_stage with a 4-cycle response watchdog.
module tb_lsu_mem_stage;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, is_load = 1'b0, is_store = 1'b0, dmem_resp = 1'b0;
  logic [2:0] funct3 = 3'b000;
  logic [31:0] addr = 32'h0, store_data = 32'h0, dmem_rdata = 32'h0;
  logic dmem_read, dmem_write, stall, done_valid, misalign_err, timeout_err;
  logic [31:0] dmem_address, dmem_wdata, load_data;
  logic [3:0] dmem_mbe;
  int errors = 0, checks = 0;
  int stalls, strobes;
  logic s_rd, s_wr, d_to, d_mis;
  logic [31:0] s_addr, s_wd, d_ld;
  logic [3:0] s_mbe;
  always #5 clk = ~clk;
  lsu_mem_stage #(.RESP_TIMEOUT(4), .TO_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_mbe(dmem_mbe), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .stall(stall),
    .done_valid(done_valid), .load_data(load_data), .misalign_err(misalign_err),
    .timeout_err(timeout_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // Issues one request at a negedge; memory answers in BUSY cycle `lat` (never if lat is large).
  task automatic access(input logic ld, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int lat);
    int i;
    i = 0;
    @(negedge clk);
    req_valid = 1'b1; is_load = ld; is_store = !ld; funct3 = f; addr = a;
    store_data = sd; dmem_rdata = rd;
    stalls = 0; strobes = 0;
    s_rd = 1'b0; s_wr = 1'b0; s_addr = 32'h0; s_wd = 32'h0; s_mbe = 4'h0;
    while (!done_valid && i < 20) begin
      dmem_resp = (i == lat);
      #1;
      if (stall) stalls++;
      if (dmem_read || dmem_write) strobes++;
      if (i == 1) begin
        s_rd = dmem_read; s_wr = dmem_write; s_addr = dmem_address;
        s_wd = dmem_wdata; s_mbe = dmem_mbe;
      end
      @(negedge clk);
      req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; dmem_resp = 1'b0;
      i++;
    end
    chk("done_seen", 32'(done_valid), 32'd1);
    chk("done_stall", 32'(stall), 32'd0);
    d_ld = load_data; d_to = timeout_err; d_mis = misalign_err;
    @(negedge clk);
    chk("done_pulse", 32'(done_valid), 32'd0);
  endtask
  initial begin
    #1;
    chk("rst_rd", 32'(dmem_read), 32'd0);
    chk("rst_wr", 32'(dmem_write), 32'd0);
    chk("rst_addr", dmem_address, 32'h0);
    chk("rst_mbe", 32'(dmem_mbe), 32'h0);
    chk("rst_done", 32'(done_valid), 32'd0);
    chk("rst_ld", load_data, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    access(1'b1, 3'b010, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 3);
    chk("lw_rd", 32'(s_rd), 32'd1);
    chk("lw_wr", 32'(s_wr), 32'd0);
    chk("lw_addr", s_addr, 32'h0000_1004);
    chk("lw_mbe", 32'(s_mbe), 32'hf);
    chk("lw_wd", s_wd, 32'h0);
    chk("lw_stalls", stalls, 4);
    chk("lw_strobes", strobes, 3);
    chk("lw_data", d_ld, 32'hDEAD_BEEF);
    chk("lw_to", 32'(d_to), 32'd0);
    access(1'b1, 3'b000, 32'h0000_1003, 32'h0, 32'h8011_2233, 1);
    chk("lb_addr", s_addr, 32'h0000_1000);
    chk("lb_stalls", stalls, 2);
    chk("lb_data", d_ld, 32'hFFFF_FF80);
    access(1'b1, 3'b100, 32'h0000_1003, 32'h0, 32'h8011_2233, 1);
    chk("lbu_data", d_ld, 32'h0000_0080);
    access(1'b1, 3'b101, 32'h0000_1002, 32'h0, 32'h8011_2233, 2);
    chk("lhu_data", d_ld, 32'h0000_8011);
    access(1'b1, 3'b001, 32'h0000_1000, 32'h0, 32'h1234_F00D, 1);
    chk("lh_data", d_ld, 32'hFFFF_F00D);
    access(1'b1, 3'b110, 32'h0000_1000, 32'h0, 32'h89AB_CDEF, 1);
    chk("lundef_data", d_ld, 32'h89AB_CDEF);
    access(1'b0, 3'b000, 32'h0000_2001, 32'h0000_00A5, 32'h0, 2);
    chk("sb_wr", 32'(s_wr), 32'd1);
    chk("sb_rd", 32'(s_rd), 32'd0);
    chk("sb_addr", s_addr, 32'h0000_2000);
    chk("sb_mbe", 32'(s_mbe), 32'h2);
    chk("sb_wd", s_wd, 32'hA5A5_A5A5);
    access(1'b0, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 1);
    chk("sh_mbe", 32'(s_mbe), 32'hc);
    chk("sh_wd", s_wd, 32'hBEEF_BEEF);
    access(1'b0, 3'b111, 32'h0000_2004, 32'h1122_3344, 32'h0, 1);
    chk("sundef_mbe", 32'(s_mbe), 32'hf);
    chk("sundef_wd", s_wd, 32'h1122_3344);
    access(1'b1, 3'b010, 32'h0000_4000, 32'h0, 32'h5555_5555, 99);
    chk("to_stalls", stalls, 5);
    chk("to_strobes", strobes, 4);
    chk("to_err", 32'(d_to), 32'd1);
    chk("to_data", d_ld, 32'h0);
    dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("late_stall", 32'(stall), 32'd0);
    @(negedge clk);
    dmem_resp = 1'b0;
    chk("late_done", 32'(done_valid), 32'd0);
    chk("late_rd", 32'(dmem_read), 32'd0);
    chk("late_data", load_data, 32'h0);
    access(1'b1, 3'b010, 32'h0000_4004, 32'h0, 32'h7777_0001, 4);
    chk("race_stalls", stalls, 5);
    chk("race_to", 32'(d_to), 32'd0);
    chk("race_data", d_ld, 32'h7777_0001);
    @(negedge clk);
    req_valid = 1'b1;
    #1;
    chk("nomem_stall", 32'(stall), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("nomem_strobe", 32'(dmem_read | dmem_write), 32'd0);
    req_valid = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h0000_5000;
    store_data = 32'h1122_3344;
    @(negedge clk);
    req_valid = 1'b0; is_store = 1'b0;
    chk("rstmid_wr1", 32'(dmem_write), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_wr", 32'(dmem_write), 32'd0);
    chk("rstmid_stall", 32'(stall), 32'd0);
    chk("rstmid_mbe", 32'(dmem_mbe), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    access(1'b1, 3'b010, 32'h0000_1008, 32'h0, 32'h0BAD_F00D, 2);
    chk("post_rst_addr", s_addr, 32'h0000_1008);
    chk("post_rst_data", d_ld, 32'h0BAD_F00D);
    access(1'b1, 3'b010, 32'h0000_3002, 32'h0, 32'hCAFE_0123, 1);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_stalls", stalls, 1);
    chk("mis_strobes", strobes, 0);
    chk("mis_err", 32'(d_mis), 32'd1);
    chk("mis_data", d_ld, 32'h0);
`else
    chk("mis_addr", s_addr, 32'h0000_3000);
    chk("mis_rd", 32'(s_rd), 32'd1);
    chk("mis_err", 32'(d_mis), 32'd0);
    chk("mis_data", d_ld, 32'hCAFE_0123);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
